// File: rtl/mdu_iter_if.sv
// Request/response bundle between decode, the iterative MDU and the rd write-back mux.
interface mdu_iter_if #(
   parameter int XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic            inst_32;
   logic [XLEN-1:0] x_rs1;
   logic [XLEN-1:0] x_rs2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] mdu_result;

   modport master (
      output in_valid, funct3, inst_32, x_rs1, x_rs2, out_ready,
      input  in_ready, out_valid, mdu_result
   );

   modport slave (
      input  in_valid, funct3, inst_32, x_rs1, x_rs2, out_ready,
      output in_ready, out_valid, mdu_result
   );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider sharing one accumulator, behind a valid/ready handshake.
module mdu_iter #(
   parameter int XLEN    = 64,
   parameter int W_ITERS = 32
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      flush,
   output logic      busy,
   mdu_iter_if.slave bus
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state;
   logic [2:0]        op_r;       // captured funct3
   logic              w_r;        // captured *W form
   logic              neg_r;      // result must be negated
   logic [CW-1:0]     cnt;        // iterations left, N-1 down to 0
   logic [XLEN-1:0]   shreg;      // bits consumed MSB-first; quotient bits shift in
   logic [XLEN-1:0]   opnd;       // multiplicand or divisor magnitude
   logic [2*XLEN-1:0] acc;        // product, or remainder in the low half

   // Request decode: operand extension, magnitudes and the latency-1 special cases.
   logic            w_in, is_div, sgn1, sgn2, neg1, neg2, res_neg;
   logic            div_zero, ovf, illegal, special;
   logic [XLEN-1:0] ext1, ext2, mag1, mag2, spec_raw, spec_res;

   function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
      return XLEN'($signed(v[31:0]));
   endfunction

   // Decode the incoming request combinationally so it can be captured on accept.
   always_comb begin
      // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
      w_in     = (XLEN == 64) && bus.inst_32;
      is_div   = bus.funct3[2];
      sgn1     = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      sgn2     = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      ext1     = bus.x_rs1;
      ext2     = bus.x_rs2;
      if (w_in) begin
         ext1 = sgn1 ? sext32(bus.x_rs1) : XLEN'(bus.x_rs1[31:0]);
         ext2 = sgn2 ? sext32(bus.x_rs2) : XLEN'(bus.x_rs2[31:0]);
      end
      neg1     = sgn1 && ext1[XLEN-1];
      neg2     = sgn2 && ext2[XLEN-1];
      mag1     = neg1 ? -ext1 : ext1;
      mag2     = neg2 ? -ext2 : ext2;
      // Remainder follows the dividend; quotient and product use the XOR of signs.
      res_neg  = (is_div && bus.funct3[1]) ? neg1 : (neg1 ^ neg2);
      div_zero = (ext2 == '0);
      ovf      = is_div && !bus.funct3[0] && (ext2 == '1) &&
                 (w_in ? (bus.x_rs1[31:0] == 32'h8000_0000)
                       : (bus.x_rs1 == {1'b1, {(XLEN-1){1'b0}}}));
      illegal  = w_in && !is_div && (bus.funct3[1:0] != 2'b00);
      special  = illegal || (is_div && (div_zero || ovf));
      spec_raw = '0;
      if (illegal)       spec_raw = '0;
      else if (div_zero) spec_raw = bus.funct3[1] ? ext1 : '1;
      else if (ovf)      spec_raw = bus.funct3[1] ? '0 : ext1;
      spec_res = w_in ? sext32(spec_raw) : spec_raw;
   end

   // One iteration step plus the post-processing applied after the last one.
   logic [2*XLEN-1:0] mul_nx, sel, sel_s;
   logic [XLEN:0]     rem_sh, rem_diff;
   logic [XLEN-1:0]   rem_nx, quo_nx, raw, fin;
   logic              ge;

   // Compute next accumulator values and the final result from them.
   always_comb begin
      mul_nx   = {acc[2*XLEN-2:0], 1'b0} + (shreg[XLEN-1] ? {{XLEN{1'b0}}, opnd} : '0);
      rem_sh   = {acc[XLEN-1:0], shreg[XLEN-1]};
      rem_diff = rem_sh - {1'b0, opnd};
      ge       = !rem_diff[XLEN];
      rem_nx   = ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      quo_nx   = {shreg[XLEN-2:0], ge};
      if (!op_r[2])    sel = mul_nx;
      else if (op_r[1]) sel = {{XLEN{1'b0}}, rem_nx};
      else              sel = {{XLEN{1'b0}}, quo_nx};
      sel_s    = neg_r ? -sel : sel;
      raw      = (!op_r[2] && (op_r[1:0] != 2'b00)) ? sel_s[2*XLEN-1:XLEN] : sel_s[XLEN-1:0];
      fin      = w_r ? sext32(raw) : raw;
   end

   // Control FSM with registered handshake outputs and the iterating datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: datapath registers are reset too, since reset must clear every accumulator.
         state          <= IDLE;
         bus.in_ready   <= 1'b1;
         bus.out_valid  <= 1'b0;
         bus.mdu_result <= '0;
         busy           <= 1'b0;
         op_r           <= '0;
         w_r            <= 1'b0;
         neg_r          <= 1'b0;
         cnt            <= '0;
         shreg          <= '0;
         opnd           <= '0;
         acc            <= '0;
      end else if (flush) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         busy          <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop sees pre-edge values of the others.
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  op_r         <= bus.funct3;
                  w_r          <= w_in;
                  neg_r        <= res_neg;
                  cnt          <= w_in ? CW'(W_ITERS - 1) : CW'(XLEN - 1);
                  acc          <= '0;
                  bus.in_ready <= 1'b0;
                  busy         <= 1'b1;
                  if (is_div) begin
                     shreg <= w_in ? (mag1 << (XLEN - W_ITERS)) : mag1;
                     opnd  <= mag2;
                  end else begin
                     shreg <= w_in ? (mag2 << (XLEN - W_ITERS)) : mag2;
                     opnd  <= mag1;
                  end
                  if (special) begin
                     bus.mdu_result <= spec_res;
                     bus.out_valid  <= 1'b1;
                     state          <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               acc   <= op_r[2] ? {{XLEN{1'b0}}, rem_nx} : mul_nx;
               shreg <= op_r[2] ? quo_nx : {shreg[XLEN-2:0], 1'b0};
               if (cnt == '0) begin
                  bus.mdu_result <= fin;
                  bus.out_valid  <= 1'b1;
                  state          <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed, table-driven bench for mdu_iter (XLEN=64) with hand-written
// sequences for backpressure, flush and reset in flight.
module tb_mdu_iter;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic busy;

   int errors = 0;
   int checks = 0;

   mdu_iter_if #(.XLEN(64)) bus ();

   mdu_iter #(.XLEN(64), .W_ITERS(32)) dut (
      .clk  (clk),
      .rst  (rst),
      .flush(flush),
      .busy (busy),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called #1 after an edge; presents a request and returns #1 after the accepting edge.
   task automatic start_op(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
      check("in_ready before request", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.funct3   = f3;
      bus.inst_32  = w;
      bus.x_rs1    = a;
      bus.x_rs2    = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.funct3   = 3'($urandom_range(0, 7));
      bus.inst_32  = 1'($urandom_range(0, 1));
      bus.x_rs1    = {$urandom, $urandom};
      bus.x_rs2    = {$urandom, $urandom};
   endtask

   // Latency 1 means out_valid is already high #1 after the accepting edge.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int lat;
      start_op(v.f3, v.w, v.a, v.b);
      wait_valid(lat);
      check({name, " result"}, bus.mdu_result, v.exp);
      check({name, " latency"}, 64'(lat), 64'(v.lat));
      @(posedge clk);
      #1;
      check({name, " idle after handshake"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
   endtask

   initial begin
      int  lat;
      bit  seen;
      vec_t v;

      //          f3      w     rs1                     rs2                     expected                lat
      vecs[0]  = '{3'b000, 1'b0, 64'd7,                  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
      vecs[1]  = '{3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65};
      vecs[2]  = '{3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 65};
      vecs[3]  = '{3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
      vecs[4]  = '{3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 33};
      vecs[5]  = '{3'b101, 1'b0, 64'd123,                64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1};
      vecs[6]  = '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0,                  64'hFFFF_FFFF_FFFF_FFFB, 1};
      vecs[7]  = '{3'b100, 1'b0, 64'd100,                64'd7,                  64'd14,                 65};
      vecs[8]  = '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 65};
      vecs[9]  = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                  64'hFFFF_FFFF_FFFF_FFF2, 65};
      vecs[10] = '{3'b001, 1'b0, 64'h4000_0000_0000_0000, 64'd4,                  64'd1,                  65};
      vecs[11] = '{3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,                  64'hFFFF_FFFF_FFFF_FFFF, 65};
      vecs[12] = '{3'b000, 1'b1, 64'h0000_0000_8000_0000, 64'd1,                  64'hFFFF_FFFF_8000_0000, 33};
      vecs[13] = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
      vecs[14] = '{3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  1};
      vecs[15] = '{3'b001, 1'b1, 64'd5,                  64'd6,                  64'd0,                  1};
      vecs[16] = '{3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2,                  64'h0000_0000_7FFF_FFFF, 33};
      vecs[17] = '{3'b111, 1'b1, 64'h0000_0000_8000_0000, 64'd0,                  64'hFFFF_FFFF_8000_0000, 1};

      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.funct3    = 3'b000;
      bus.inst_32   = 1'b0;
      bus.x_rs1     = '0;
      bus.x_rs2     = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state.
      check("reset in_ready", 64'(bus.in_ready), 64'd1);
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset mdu_result", bus.mdu_result, 64'd0);

      for (int i = 0; i < 18; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Backpressure: DONE is held while out_ready is low.
      bus.out_ready = 1'b0;
      start_op(3'b100, 1'b0, 64'd100, 64'd7);
      wait_valid(lat);
      check("bp latency", 64'(lat), 64'd65);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp hold%0d out_valid", i), 64'(bus.out_valid), 64'd1);
         check($sformatf("bp hold%0d result", i), bus.mdu_result, 64'd14);
         check($sformatf("bp hold%0d in_ready", i), 64'(bus.in_ready), 64'd0);
         check($sformatf("bp hold%0d busy", i), 64'(busy), 64'd1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp release in_ready", 64'(bus.in_ready), 64'd1);
      check("bp release out_valid", 64'(bus.out_valid), 64'd0);
      check("bp result kept", bus.mdu_result, 64'd14);

      // Flush together with in_valid in IDLE: request is not accepted.
      bus.in_valid = 1'b1;
      bus.funct3   = 3'b101;
      bus.x_rs1    = 64'd9;
      bus.x_rs2    = 64'd0;
      flush        = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      flush        = 1'b0;
      check("idle flush in_ready", 64'(bus.in_ready), 64'd1);
      check("idle flush busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      check("idle flush no out_valid", 64'(bus.out_valid), 64'd0);

      // Flush at iteration 10 of a division.
      start_op(3'b100, 1'b0, 64'd1000, 64'd3);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("calc flush out_valid", 64'(bus.out_valid), 64'd0);
      check("calc flush in_ready", 64'(bus.in_ready), 64'd1);
      check("calc flush busy", 64'(busy), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      check("calc flush no result", 64'(seen), 64'd0);
      v = '{3'b100, 1'b0, 64'd100, 64'd7, 64'd14, 65};
      run_vec("after flush div", v);

      // Reset at iteration 10 of a multiply.
      start_op(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("calc reset mdu_result", bus.mdu_result, 64'd0);
      check("calc reset out_valid", 64'(bus.out_valid), 64'd0);
      check("calc reset in_ready", 64'(bus.in_ready), 64'd1);
      run_vec("after reset div", v);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
